immediate_extender: RTL and testbench



---
 rtl/instruction_pkg.sv | 39 +++
 rtl/immediate_extender_if.sv | 33 +++
 rtl/immediate_extender_imm_format_decoder.sv | 31 +++
 rtl/immediate_extender.sv | 68 ++++++
 tb/tb_immediate_extender.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_pkg.sv
// instruction_pkg: shared RISC-V instruction word and opcode types, plus the
// immediate format tags used by the decode stage.
`default_nettype none

package instruction_pkg;

    typedef enum logic [6:0] {
        UlaIType   = 7'b0010011,
        UlaIWType  = 7'b0011011,
        LoadType   = 7'b0000011,
        Jalr       = 7'b1100111,
        Fence      = 7'b0001111,
        SystemType = 7'b1110011,
        SType      = 7'b0100011,
        BType      = 7'b1100011,
        Lui        = 7'b0110111,
        Auipc      = 7'b0010111,
        Jal        = 7'b1101111,
        UlaRType   = 7'b0110011,
        UlaRWType  = 7'b0111011
    } opcode_t;

    typedef struct packed {
        logic [24:0] payload;
        opcode_t     opcode;
    } instruction_t;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } imm_format_t;

endpackage

`default_nettype wire

// File: rtl/immediate_extender_if.sv
// immediate_extender_if: instruction in, extended immediate (combinational
// and registered) out.
`default_nettype none

interface immediate_extender_if
    import instruction_pkg::*;
#(
    parameter int N = 64
);
    instruction_t   instruction;
    logic           enable;
    logic [N-1:0]   immediate;
    logic           has_immediate;
    logic [N-1:0]   immediate_reg;

    modport master (
        output instruction,
        output enable,
        input  immediate,
        input  has_immediate,
        input  immediate_reg
    );

    modport slave (
        input  instruction,
        input  enable,
        output immediate,
        output has_immediate,
        output immediate_reg
    );
endinterface

`default_nettype wire

// File: rtl/immediate_extender_imm_format_decoder.sv
// imm_format_decoder: maps an opcode to its immediate format and flags whether
// the instruction carries an immediate at all.
`default_nettype none

module imm_format_decoder
    import instruction_pkg::*;
(
    input  opcode_t     opcode,
    output imm_format_t format,
    output logic        has_immediate
);

    always_comb begin
        format = FMT_NONE;
        unique case (opcode)
            UlaIType, UlaIWType, LoadType,
            Jalr, Fence, SystemType:        format = FMT_I;
            SType:                          format = FMT_S;
            BType:                          format = FMT_B;
            Lui, Auipc:                     format = FMT_U;
            Jal:                            format = FMT_J;
            UlaRType, UlaRWType:            format = FMT_NONE;
            default:                        format = FMT_NONE;
        endcase
    end

    assign has_immediate = (format != FMT_NONE);

endmodule

`default_nettype wire

// File: rtl/immediate_extender.sv
// immediate_extender: extracts and sign-extends the RISC-V immediate to N bits,
// combinationally and through an enable-loaded register.
`default_nettype none

module immediate_extender
    import instruction_pkg::*;
#(
    parameter int N = 64
)(
    input  wire logic          clock,
    input  wire logic          reset,
    immediate_extender_if.slave bus
);

    logic [31:0]  word;
    imm_format_t  format;
    logic         flag;
    logic [31:0]  imm32;
    logic [N-1:0] imm_full;
    logic [N-1:0] held_immediate;

    assign word = bus.instruction;

    imm_format_decoder u_format_decoder (
        .opcode        (bus.instruction.opcode),
        .format        (format),
        .has_immediate (flag)
    );

    // Every format's sign bit is word[31], so a 32-bit intermediate is enough
    // before widening to N.
    always_comb begin
        imm32 = 32'd0;
        case (format)
            FMT_I:   imm32 = {{20{word[31]}}, word[31:20]};
            FMT_S:   imm32 = {{20{word[31]}}, word[31:25], word[11:7]};
            FMT_B:   imm32 = {{19{word[31]}}, word[31], word[7], word[30:25],
                              word[11:8], 1'b0};
            FMT_U:   imm32 = {word[31:12], 12'd0};
            FMT_J:   imm32 = {{11{word[31]}}, word[31], word[19:12], word[20],
                              word[30:21], 1'b0};
            default: imm32 = 32'd0;
        endcase
    end

    generate
        if (N > 32) begin : g_wide
            assign imm_full = {{(N-32){imm32[31]}}, imm32};
        end else begin : g_narrow
            assign imm_full = imm32[N-1:0];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset) begin
            held_immediate <= '0;
        end else if (bus.enable) begin
            held_immediate <= imm_full;
        end
    end

    assign bus.immediate     = imm_full;
    assign bus.has_immediate = flag;
    assign bus.immediate_reg = held_immediate;

endmodule

`default_nettype wire

// File: tb/tb_immediate_extender.sv
// tb_immediate_extender: directed format vectors, register sequence and a
// randomized check against an independent format model (N = 64 and N = 32).
`default_nettype none

module tb_immediate_extender;

    logic clock;
    logic reset;
    int   compared;
    int   mismatched;

    immediate_extender_if #(.N(64)) bus64 ();
    immediate_extender_if #(.N(32)) bus32 ();

    immediate_extender #(.N(64)) dut64 (
        .clock (clock),
        .reset (reset),
        .bus   (bus64.slave)
    );

    immediate_extender #(.N(32)) dut32 (
        .clock (clock),
        .reset (reset),
        .bus   (bus32.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [63:0] ref_imm(input logic [31:0] i);
        logic [63:0] r;
        r = 64'd0;
        case (i[6:0])
            7'b0010011, 7'b0011011, 7'b0000011,
            7'b1100111, 7'b0001111, 7'b1110011:
                r = {{52{i[31]}}, i[31:20]};
            7'b0100011: r = {{52{i[31]}}, i[31:25], i[11:7]};
            7'b1100011: r = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            7'b0110111, 7'b0010111: r = {{32{i[31]}}, i[31:12], 12'd0};
            7'b1101111: r = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default:    r = 64'd0;
        endcase
        return r;
    endfunction

    function automatic logic ref_has(input logic [31:0] i);
        case (i[6:0])
            7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111, 7'b0001111,
            7'b1110011, 7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
            7'b1101111: return 1'b1;
            default:    return 1'b0;
        endcase
    endfunction

    task automatic drive(input logic [31:0] instr);
        bus64.instruction = instr;
        bus32.instruction = instr;
        #5;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus64.enable = 1'b1;
        bus32.enable = 1'b1;
        bus64.instruction = 32'hFFF00093;
        bus32.instruction = 32'hFFF00093;
        @(posedge clock); #1;
        compared++;
        if (bus64.immediate_reg !== 64'd0) begin
            mismatched++;
            $display("FAIL reset_reg64 got %h want %h", bus64.immediate_reg, 64'd0);
        end
        compared++;
        if (bus32.immediate_reg !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_reg32 got %h want %h", bus32.immediate_reg, 32'd0);
        end
        compared++;
        if (bus64.immediate !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            mismatched++;
            $display("FAIL comb_during_reset got %h want %h", bus64.immediate,
                     64'hFFFF_FFFF_FFFF_FFFF);
        end
    endtask

    task automatic test_directed();
        logic [31:0] instrs [10];
        logic [63:0] want   [10];
        logic        whas   [10];
        instrs[0] = 32'hFFF00093; want[0] = 64'hFFFF_FFFF_FFFF_FFFF; whas[0] = 1'b1;
        instrs[1] = 32'hFE112E23; want[1] = 64'hFFFF_FFFF_FFFF_FFFC; whas[1] = 1'b1;
        instrs[2] = 32'h00000863; want[2] = 64'h0000_0000_0000_0010; whas[2] = 1'b1;
        instrs[3] = 32'hFFDFF06F; want[3] = 64'hFFFF_FFFF_FFFF_FFFC; whas[3] = 1'b1;
        instrs[4] = 32'h800000B7; want[4] = 64'hFFFF_FFFF_8000_0000; whas[4] = 1'b1;
        instrs[5] = 32'h002081B3; want[5] = 64'h0;                   whas[5] = 1'b0;
        instrs[6] = 32'h4030D093; want[6] = 64'h0000_0000_0000_0403; whas[6] = 1'b1;
        instrs[7] = 32'h00100073; want[7] = 64'h0000_0000_0000_0001; whas[7] = 1'b1;
        instrs[8] = 32'hFFFFF117; want[8] = 64'hFFFF_FFFF_FFFF_F000; whas[8] = 1'b1;
        instrs[9] = 32'hFFFFFF7F; want[9] = 64'h0;                   whas[9] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            drive(instrs[k]);
            compared++;
            if (bus64.immediate !== want[k]) begin
                mismatched++;
                $display("FAIL directed_imm64[%0d] instr %h got %h want %h",
                         k, instrs[k], bus64.immediate, want[k]);
            end
            compared++;
            if (bus32.immediate !== want[k][31:0]) begin
                mismatched++;
                $display("FAIL directed_imm32[%0d] instr %h got %h want %h",
                         k, instrs[k], bus32.immediate, want[k][31:0]);
            end
            compared++;
            if (bus64.has_immediate !== whas[k]) begin
                mismatched++;
                $display("FAIL directed_has[%0d] instr %h got %b want %b",
                         k, instrs[k], bus64.has_immediate, whas[k]);
            end
        end
    endtask

    task automatic test_register();
        @(negedge clock);
        reset = 1'b1;
        bus64.enable = 1'b1;
        bus32.enable = 1'b1;
        bus64.instruction = 32'hFFF00093;
        bus32.instruction = 32'hFFF00093;
        @(posedge clock); #1;
        compared++;
        if (bus64.immediate_reg !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            mismatched++;
            $display("FAIL reg_load got %h want %h", bus64.immediate_reg,
                     64'hFFFF_FFFF_FFFF_FFFF);
        end
        @(negedge clock);
        bus64.enable = 1'b0;
        bus32.enable = 1'b0;
        bus64.instruction = 32'h00000863;
        bus32.instruction = 32'h00000863;
        @(posedge clock); #1;
        compared++;
        if (bus64.immediate_reg !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            mismatched++;
            $display("FAIL reg_hold got %h want %h", bus64.immediate_reg,
                     64'hFFFF_FFFF_FFFF_FFFF);
        end
        @(negedge clock);
        bus64.enable = 1'b1;
        bus32.enable = 1'b1;
        @(posedge clock); #1;
        compared++;
        if (bus64.immediate_reg !== 64'h10) begin
            mismatched++;
            $display("FAIL reg_reload got %h want %h", bus64.immediate_reg, 64'h10);
        end
        compared++;
        if (bus32.immediate_reg !== 32'h10) begin
            mismatched++;
            $display("FAIL reg_reload32 got %h want %h", bus32.immediate_reg, 32'h10);
        end
        // Reset must win over a simultaneous enable.
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        compared++;
        if (bus64.immediate_reg !== 64'd0) begin
            mismatched++;
            $display("FAIL reg_reset_priority got %h want %h", bus64.immediate_reg, 64'd0);
        end
        @(negedge clock);
        reset = 1'b1;
        bus64.enable = 1'b0;
        bus32.enable = 1'b0;
    endtask

    task automatic test_random();
        logic [6:0]  ops [13];
        logic [31:0] instr;
        logic [63:0] want;
        ops[0]  = 7'b0010011; ops[1]  = 7'b0011011; ops[2]  = 7'b0000011;
        ops[3]  = 7'b1100111; ops[4]  = 7'b0001111; ops[5]  = 7'b1110011;
        ops[6]  = 7'b0100011; ops[7]  = 7'b1100011; ops[8]  = 7'b0110111;
        ops[9]  = 7'b0010111; ops[10] = 7'b1101111; ops[11] = 7'b0110011;
        ops[12] = 7'b0111011;
        for (int n = 0; n < 10000; n++) begin
            instr = $urandom;
            instr[6:0] = ops[$urandom_range(0, 12)];
            want = ref_imm(instr);
            drive(instr);
            compared++;
            if (bus64.immediate !== want) begin
                mismatched++;
                $display("FAIL random_imm64 instr %h got %h want %h",
                         instr, bus64.immediate, want);
            end
            compared++;
            if (bus32.immediate !== want[31:0]) begin
                mismatched++;
                $display("FAIL random_imm32 instr %h got %h want %h",
                         instr, bus32.immediate, want[31:0]);
            end
            compared++;
            if (bus64.has_immediate !== ref_has(instr)) begin
                mismatched++;
                $display("FAIL random_has instr %h got %b want %b",
                         instr, bus64.has_immediate, ref_has(instr));
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b0;
        bus64.enable = 1'b0;
        bus32.enable = 1'b0;
        bus64.instruction = 32'd0;
        bus32.instruction = 32'd0;
        @(negedge clock);
        test_reset();
        test_directed();
        test_register();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
